// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared types, defaults and width helper for the debounce bank
package debounce_pkg;

    localparam int DEFAULT_STABLE_CYCLES = 16;

    function automatic int cnt_width(input int stable);
        return $clog2(stable + 1);
    endfunction

    typedef logic [cnt_width(DEFAULT_STABLE_CYCLES)-1:0] debounce_cnt_t;

endpackage

// File: rtl/debounce_chan.sv
// rtl/debounce_chan.sv - one channel: synchroniser, stability counter, clean level, edge pulses
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int SYNC_STAGES   = 2,
    parameter bit RESET_LEVEL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic dirty,
    output logic clean,
    output logic rise,
    output logic fall
);

    localparam int CW = cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt;
    logic                   sync;

    assign sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RESET_LEVEL}};
            clean  <= RESET_LEVEL;
            cnt    <= '0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], dirty};
            rise   <= 1'b0;
            fall   <= 1'b0;
            // Any sample agreeing with clean restarts the stability count.
            if (sync == clean) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                clean <= sync;
                cnt   <= '0;
                rise  <= sync;
                fall  <= ~sync;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/debounce_bank.sv
// rtl/debounce_bank.sv - multi-channel debouncer with optional sticky IRQ bits (DEBOUNCE_BANK_IRQ_EN)
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int CHANNELS      = 8,
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int SYNC_STAGES   = 2,
    parameter bit RESET_LEVEL   = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] dirty,
    output logic [CHANNELS-1:0] clean,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    input  logic [CHANNELS-1:0] irq_rise_en,
    input  logic [CHANNELS-1:0] irq_fall_en,
    input  logic [CHANNELS-1:0] irq_ack,
    output logic [CHANNELS-1:0] irq_pending,
    output logic                irq
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        debounce_chan #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .SYNC_STAGES   (SYNC_STAGES),
            .RESET_LEVEL   (RESET_LEVEL)
        ) u_chan (
            .clk   (clk),
            .rst   (rst),
            .dirty (dirty[i]),
            .clean (clean[i]),
            .rise  (rise[i]),
            .fall  (fall[i])
        );
    end

`ifdef DEBOUNCE_BANK_IRQ_EN
    logic [CHANNELS-1:0] pend_next;

    // Set terms are ORed after the ack mask so a new edge wins over a same-cycle ack.
    always_comb begin
        pend_next = (irq_pending & ~irq_ack) | (rise & irq_rise_en) | (fall & irq_fall_en);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_pending <= '0;
            irq         <= 1'b0;
        end else begin
            irq_pending <= pend_next;
            irq         <= |pend_next;
        end
    end
`else
    logic unused_irq_inputs;

    assign unused_irq_inputs = ^{irq_rise_en, irq_fall_en, irq_ack};
    assign irq_pending       = '0;
    assign irq               = 1'b0;
`endif

endmodule
